// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM. It steps one instruction at a time through IF/ID/EX/MEM/WB.
// All datapath strobes are decoded combinationally from the state, the latched instruction and the latched Zero flag.
module multicycle_control #(
  parameter bit ENABLE_SHIFTS = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             Zero,
  output logic             PCSrc,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic             loadPC,
  output logic [3:0]       ALUCtrl,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_XOR  = 4'b1101;

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      ir_q      <= '0;
      zero_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      zero_q    <= zero_d;
      retired_q <= retired_d;
    end
  end

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_base, f7_alt;

  assign opcode  = ir_q[6:0];
  assign funct3  = ir_q[14:12];
  assign funct7  = ir_q[31:25];
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);

  // Register and immediate fields belong to the datapath; only the decode fields are read here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^{ir_q[24:15], ir_q[11:7]};

  logic       is_r, is_i, is_lw, is_sw, is_beq, is_ill;
  logic [3:0] alu_ctrl;

  // Instruction class and ALU op. Anything left unclaimed here is illegal and runs the ALU as ADD.
  always_comb begin
    is_r     = 1'b0;
    is_i     = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_beq   = 1'b0;
    alu_ctrl = ALU_ADD;
    case (opcode)
      OP_REG: begin
        case (funct3)
          3'b000: begin
            if (f7_base) begin
              is_r     = 1'b1;
              alu_ctrl = ALU_ADD;
            end else if (f7_alt) begin
              is_r     = 1'b1;
              alu_ctrl = ALU_SUB;
            end
          end
          3'b001: begin
            if (ENABLE_SHIFTS && f7_base) begin
              is_r     = 1'b1;
              alu_ctrl = ALU_SLL;
            end
          end
          3'b010: begin
            if (f7_base) begin
              is_r     = 1'b1;
              alu_ctrl = ALU_SLT;
            end
          end
          3'b011: begin
            if (f7_base) begin
              is_r     = 1'b1;
              alu_ctrl = ALU_SLTU;
            end
          end
          3'b100: begin
            if (f7_base) begin
              is_r     = 1'b1;
              alu_ctrl = ALU_XOR;
            end
          end
          3'b101: begin
            if (ENABLE_SHIFTS && f7_base) begin
              is_r     = 1'b1;
              alu_ctrl = ALU_SRL;
            end else if (ENABLE_SHIFTS && f7_alt) begin
              is_r     = 1'b1;
              alu_ctrl = ALU_SRA;
            end
          end
          3'b110: begin
            if (f7_base) begin
              is_r     = 1'b1;
              alu_ctrl = ALU_OR;
            end
          end
          default: begin
            if (f7_base) begin
              is_r     = 1'b1;
              alu_ctrl = ALU_AND;
            end
          end
        endcase
      end
      OP_IMM: begin
        // Bits 31:25 are immediate bits except for the shift-immediate forms.
        case (funct3)
          3'b000: begin
            is_i     = 1'b1;
            alu_ctrl = ALU_ADD;
          end
          3'b001: begin
            if (ENABLE_SHIFTS && f7_base) begin
              is_i     = 1'b1;
              alu_ctrl = ALU_SLL;
            end
          end
          3'b010: begin
            is_i     = 1'b1;
            alu_ctrl = ALU_SLT;
          end
          3'b011: begin
            is_i     = 1'b1;
            alu_ctrl = ALU_SLTU;
          end
          3'b100: begin
            is_i     = 1'b1;
            alu_ctrl = ALU_XOR;
          end
          3'b101: begin
            if (ENABLE_SHIFTS && f7_base) begin
              is_i     = 1'b1;
              alu_ctrl = ALU_SRL;
            end else if (ENABLE_SHIFTS && f7_alt) begin
              is_i     = 1'b1;
              alu_ctrl = ALU_SRA;
            end
          end
          3'b110: begin
            is_i     = 1'b1;
            alu_ctrl = ALU_OR;
          end
          default: begin
            is_i     = 1'b1;
            alu_ctrl = ALU_AND;
          end
        endcase
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          is_lw = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          is_sw = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          is_beq   = 1'b1;
          alu_ctrl = ALU_SUB;
        end
      end
      default: begin
      end
    endcase
  end

  assign is_ill = ~(is_r | is_i | is_lw | is_sw | is_beq);

  // Next state, register captures and strobes.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    zero_d    = zero_q;
    retired_d = retired_q;
    PCSrc     = 1'b0;
    RegWrite  = 1'b0;
    MemToReg  = 1'b0;
    loadPC    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    illegal   = 1'b0;
    ALUCtrl   = alu_ctrl;
    ALUSrc    = is_i | is_lw | is_sw;
    case (state_q)
      S_IF: begin
        ir_d    = instr;
        state_d = S_ID;
      end
      S_ID: begin
        state_d = S_EX;
      end
      S_EX: begin
        zero_d = Zero;
        // The datapath picks the load immediate over the store offset by looking at RegWrite on this edge.
        RegWrite = is_lw;
        state_d  = (is_lw | is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        MemToReg = is_lw;
        state_d  = S_WB;
      end
      S_WB: begin
        RegWrite  = is_r | is_i | is_lw;
        MemToReg  = is_lw;
        loadPC    = 1'b1;
        PCSrc     = is_beq & zero_q;
        illegal   = is_ill;
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_IF;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a table of known instructions plus hand-written reset and wrap sequences.
// A random instruction stream is checked against a class-level model of the control rules.
module tb_multicycle_control;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111, A_SRL = 4'b1000, A_SLL = 4'b1001, A_SRA = 4'b1010;
  localparam logic [3:0] A_SLTU = 4'b1011, A_XOR = 4'b1101;
  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_ILL = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        Zero;

  logic a_pcsrc, a_alusrc, a_regwrite, a_memtoreg, a_loadpc, a_memread, a_memwrite, a_illegal;
  logic b_pcsrc, b_alusrc, b_regwrite, b_memtoreg, b_loadpc, b_memread, b_memwrite, b_illegal;
  logic [3:0]  a_alu, b_alu;
  logic [2:0]  a_state, b_state;
  logic [31:0] a_retired;
  logic [2:0]  b_retired;

  multicycle_control #(.ENABLE_SHIFTS(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
    .PCSrc(a_pcsrc), .ALUSrc(a_alusrc), .RegWrite(a_regwrite), .MemToReg(a_memtoreg),
    .loadPC(a_loadpc), .ALUCtrl(a_alu), .MemRead(a_memread), .MemWrite(a_memwrite),
    .illegal(a_illegal), .state(a_state), .retired(a_retired)
  );

  // Second copy: no shifts and a narrow counter so the wrap is reachable in a few instructions.
  multicycle_control #(.ENABLE_SHIFTS(1'b0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
    .PCSrc(b_pcsrc), .ALUSrc(b_alusrc), .RegWrite(b_regwrite), .MemToReg(b_memtoreg),
    .loadPC(b_loadpc), .ALUCtrl(b_alu), .MemRead(b_memread), .MemWrite(b_memwrite),
    .illegal(b_illegal), .state(b_state), .retired(b_retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  logic [3:0]  alu_of_f3 [8];
  logic [31:0] ret_a_exp;
  logic [2:0]  ret_b_exp;
  logic [31:0] prev_ins;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (txn %0d, t=%0t)", name, got, want, txn, $time);
    end
  endtask

  // Instruction class and ALU operation from the RV32I subset rules.
  function automatic void ref_decode(input logic [31:0] ins, input bit shifts,
                                     output int cls, output logic [3:0] alu);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    bit shift_op = (f3 == 3'd1) || (f3 == 3'd5);
    bit alt = (f7 == 7'h20);
    cls = C_ILL;
    alu = A_ADD;
    if (op == 7'h33) begin
      if (((f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5))) && (!shift_op || shifts)) begin
        cls = C_R;
        alu = alt ? ((f3 == 3'd0) ? A_SUB : A_SRA) : alu_of_f3[f3];
      end
    end else if (op == 7'h13) begin
      if (!shift_op) begin
        cls = C_I;
        alu = alu_of_f3[f3];
      end else if (shifts && ((f7 == 7'h00) || (alt && f3 == 3'd5))) begin
        cls = C_I;
        alu = alt ? A_SRA : alu_of_f3[f3];
      end
    end else if (op == 7'h03 && f3 == 3'd2) begin
      cls = C_LW;
    end else if (op == 7'h23 && f3 == 3'd2) begin
      cls = C_SW;
    end else if (op == 7'h63 && f3 == 3'd0) begin
      cls = C_BEQ;
      alu = A_SUB;
    end
  endfunction

  // {state, ALUCtrl, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, PCSrc, illegal}
  function automatic logic [14:0] ref_outputs(input int st, input int cls, input logic [3:0] alu, input bit zq);
    bit ex = (st == 2), mem = (st == 3), wb = (st == 4);
    bit src = (cls == C_I) || (cls == C_LW) || (cls == C_SW);
    bit rw  = (wb && (cls == C_R || cls == C_I || cls == C_LW)) || (ex && cls == C_LW);
    bit m2r = (cls == C_LW) && (mem || wb);
    bit mr  = mem && (cls == C_LW);
    bit mw  = mem && (cls == C_SW);
    bit pcs = wb && (cls == C_BEQ) && zq;
    bit ill = wb && (cls == C_ILL);
    logic [2:0] s3 = st[2:0];
    return {s3, alu, src, rw, m2r, wb, mr, mw, pcs, ill};
  endfunction

  function automatic logic [14:0] bundle_a();
    return {a_state, a_alu, a_alusrc, a_regwrite, a_memtoreg, a_loadpc, a_memread, a_memwrite, a_pcsrc, a_illegal};
  endfunction

  function automatic logic [14:0] bundle_b();
    return {b_state, b_alu, b_alusrc, b_regwrite, b_memtoreg, b_loadpc, b_memread, b_memwrite, b_pcsrc, b_illegal};
  endfunction

  // Runs one instruction starting in IF (called just after a rising edge); zpat[s] is Zero while in state s.
  task automatic run_instr(input logic [31:0] ins, input logic [4:0] zpat,
                           output logic [14:0] trace, output logic [3:0] alu_ex, output logic src_ex,
                           output logic [4:0] wb_a, output logic ill_b);
    int cls_a, cls_b, pcls_a, pcls_b;
    logic [3:0] alu_a, alu_b, palu_a, palu_b;
    int seq[$];
    ref_decode(ins, 1'b1, cls_a, alu_a);
    ref_decode(ins, 1'b0, cls_b, alu_b);
    ref_decode(prev_ins, 1'b1, pcls_a, palu_a);
    ref_decode(prev_ins, 1'b0, pcls_b, palu_b);
    if (cls_a == C_LW || cls_a == C_SW) seq = '{0, 1, 2, 3, 4};
    else seq = '{0, 1, 2, 4};
    trace = '0; alu_ex = '0; src_ex = 1'b0; wb_a = '0; ill_b = 1'b0;
    instr = ins;
    foreach (seq[k]) begin
      int st = seq[k];
      Zero = zpat[st];
      @(negedge clk);
      chk("ctl_a", {17'd0, bundle_a()},
          {17'd0, ref_outputs(st, (st == 0) ? pcls_a : cls_a, (st == 0) ? palu_a : alu_a, zpat[2])});
      chk("ctl_b", {17'd0, bundle_b()},
          {17'd0, ref_outputs(st, (st == 0) ? pcls_b : cls_b, (st == 0) ? palu_b : alu_b, zpat[2])});
      chk("retired_a", a_retired, ret_a_exp);
      chk("retired_b", {29'd0, b_retired}, {29'd0, ret_b_exp});
      trace = trace | (15'(a_state) << (3 * k));
      if (st == 2) begin
        alu_ex = a_alu;
        src_ex = a_alusrc;
      end
      if (st == 4) begin
        wb_a  = {a_regwrite, a_loadpc, a_pcsrc, a_illegal, a_memwrite};
        ill_b = b_illegal;
      end
      @(posedge clk);
      #1;
      if (st == 4) begin
        ret_a_exp++;
        ret_b_exp++;
      end
    end
    prev_ins = ins;
    Zero = 1'b0;
    for (int w = 0; w < 8 && a_state != 3'd0; w++) begin
      @(posedge clk);
      #1;
    end
    chk("back_to_if", {29'd0, a_state}, 32'd0);
    $display("txn %0d ins=%08h cls=%0d/%0d cycles=%0d", txn, ins, cls_a, cls_b, seq.size());
    txn++;
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [4:0]  zpat;
    logic [3:0]  alu;
    logic        src;
    logic [14:0] trace;
    logic [4:0]  wb;     // {RegWrite, loadPC, PCSrc, illegal, MemWrite} in WB
    logic        ill_b;  // illegal in WB with shifts disabled
  } vec_t;

  localparam logic [14:0] TR4 = 15'h0888;  // IF, ID, EX, WB
  localparam logic [14:0] TR5 = 15'h4688;  // IF, ID, EX, MEM, WB

  vec_t        vecs [8];
  logic [14:0] o_trace;
  logic [3:0]  o_alu;
  logic        o_src, o_ill_b;
  logic [4:0]  o_wb;
  logic [31:0] rnd;
  logic [6:0]  ops [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_of_f3[0] = A_ADD; alu_of_f3[1] = A_SLL; alu_of_f3[2] = A_SLT; alu_of_f3[3] = A_SLTU;
    alu_of_f3[4] = A_XOR; alu_of_f3[5] = A_SRL; alu_of_f3[6] = A_OR;  alu_of_f3[7] = A_AND;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;

    vecs[0] = '{"add",   32'h002081B3, 5'b00000, A_ADD, 1'b0, TR4, 5'b11000, 1'b0};
    vecs[1] = '{"sub",   32'h402081B3, 5'b00000, A_SUB, 1'b0, TR4, 5'b11000, 1'b0};
    vecs[2] = '{"srai",  32'h4030D213, 5'b00000, A_SRA, 1'b1, TR4, 5'b11000, 1'b1};
    vecs[3] = '{"lw",    32'h00812283, 5'b00000, A_ADD, 1'b1, TR5, 5'b11000, 1'b0};
    vecs[4] = '{"sw",    32'h00512623, 5'b00000, A_ADD, 1'b1, TR5, 5'b01000, 1'b0};
    vecs[5] = '{"beq_t", 32'h00208463, 5'b00100, A_SUB, 1'b0, TR4, 5'b01100, 1'b0};
    vecs[6] = '{"beq_n", 32'h00208463, 5'b10010, A_SUB, 1'b0, TR4, 5'b01000, 1'b0};
    vecs[7] = '{"ill7f", 32'h0000007F, 5'b00000, A_ADD, 1'b0, TR4, 5'b01010, 1'b1};

    rst = 1'b1; instr = '0; Zero = 1'b0;
    ret_a_exp = '0; ret_b_exp = '0; prev_ins = '0;

    // Reset state: IF, ir cleared (decodes as illegal -> ADD), no strobes, counter zero.
    #2;
    chk("reset_ctl_a", {17'd0, bundle_a()}, {17'd0, ref_outputs(0, C_ILL, A_ADD, 1'b0)});
    chk("reset_ctl_b", {17'd0, bundle_b()}, {17'd0, ref_outputs(0, C_ILL, A_ADD, 1'b0)});
    chk("reset_retired", a_retired, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_instr(vecs[i].ins, vecs[i].zpat, o_trace, o_alu, o_src, o_wb, o_ill_b);
      chk({vecs[i].name, "_trace"}, {17'd0, o_trace}, {17'd0, vecs[i].trace});
      chk({vecs[i].name, "_alu"}, {28'd0, o_alu}, {28'd0, vecs[i].alu});
      chk({vecs[i].name, "_alusrc"}, {31'd0, o_src}, {31'd0, vecs[i].src});
      chk({vecs[i].name, "_wb"}, {27'd0, o_wb}, {27'd0, vecs[i].wb});
      chk({vecs[i].name, "_ill_noshift"}, {31'd0, o_ill_b}, {31'd0, vecs[i].ill_b});
    end

    // Reset in the MEM cycle of a store: MemWrite must drop without waiting for a clock edge.
    instr = 32'h00512623;
    Zero = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("sw_mem_write", {31'd0, a_memwrite}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_memwrite", {31'd0, a_memwrite}, 32'd0);
    chk("rst_loadpc", {31'd0, a_loadpc}, 32'd0);
    chk("rst_state", {29'd0, a_state}, 32'd0);
    chk("rst_retired", a_retired, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_state", {29'd0, a_state}, 32'd0);
    rst = 1'b0;
    ret_a_exp = '0; ret_b_exp = '0; prev_ins = '0;
    run_instr(32'h002081B3, 5'b00000, o_trace, o_alu, o_src, o_wb, o_ill_b);
    chk("retired_after_rst", a_retired, 32'd1);

    // Narrow counter reaches all-ones then wraps to zero on the next WB.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ret_a_exp = '0; ret_b_exp = '0; prev_ins = '0;
    repeat (7) run_instr(32'h002081B3, 5'b00000, o_trace, o_alu, o_src, o_wb, o_ill_b);
    chk("wrap_all_ones", {29'd0, b_retired}, 32'd7);
    run_instr(32'h0000007F, 5'b00000, o_trace, o_alu, o_src, o_wb, o_ill_b);
    chk("wrap_to_zero", {29'd0, b_retired}, 32'd0);
    chk("wide_count", a_retired, 32'd8);

    // Random instruction stream, biased towards the decodable opcodes.
    for (int n = 0; n < 150; n++) begin
      int sel;
      int f7sel;
      rnd = $urandom;
      sel = $urandom_range(0, 5);
      if (sel < 5) rnd[6:0] = ops[sel];
      f7sel = $urandom_range(0, 2);
      if (f7sel == 0) rnd[31:25] = 7'h00;
      else if (f7sel == 1) rnd[31:25] = 7'h20;
      if (sel >= 2 && sel <= 4 && $urandom_range(0, 3) != 0) rnd[14:12] = (sel == 4) ? 3'd0 : 3'd2;
      run_instr(rnd, 5'($urandom), o_trace, o_alu, o_src, o_wb, o_ill_b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
